// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small prefetch FIFO of {pc, inst} entries with flush; head reads 0 when empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [AW:0]  count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count < (AW+1)'(DEPTH) || do_pop);
  assign head = count != '0 ? mem[rd] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (do_pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: drives the instruction ROM, buffers fetched words, handles redirects and range faults
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1432,
  parameter logic [WIDTH-1:0] RESET_PC = FETCH_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] rom_address,
  input  logic [WIDTH-1:0] rom_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             fetch_fault
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(DEPTH) << 2;
  logic [WIDTH-1:0] fetch_pc, pc_next;
  logic fault, fault_next, in_range, push, pop;
  logic [CW-1:0] count;
  fetch_entry_t head;
  assign in_range = {1'b0, fetch_pc} < LIMIT;
  assign inst_valid = count != '0;
  assign pop = inst_valid && inst_ready;
  assign push = !fault && in_range && (count < CW'(FIFO_DEPTH) || pop);
  // a redirect overrides push/pop; the FIFO flush takes precedence internally
  always_comb begin
    pc_next = redirect_valid ? {redirect_pc[WIDTH-1:2], 2'b00} : push ? fetch_pc + WIDTH'(4) : fetch_pc;
    fault_next = redirect_valid ? |redirect_pc[1:0] : fault | !in_range;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      fault <= 1'b0;
    end else begin
      fetch_pc <= pc_next;
      fault <= fault_next;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din('{pc: fetch_pc, inst: rom_rdata}),
    .head(head),
    .count(count)
  );
  assign rom_address = fetch_pc;
  assign inst = head.inst;
  assign inst_pc = head.pc;
  assign fetch_fault = fault;
endmodule
